// File: rtl/fifo_rd_drain.sv
// Read-side drain controller: pops a programmed burst from the FIFO, absorbs its
// one-cycle read latency and streams words out through a 2-entry skid buffer.
// Optional handshake counter is built when FIFO_RD_DRAIN_STAT_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; burst_len sampled here
// READ  | issuing pops while the buffer has room and words remain
// FLUSH | all pops issued; draining in-flight word and buffer
// DONE  | one-cycle completion pulse
module fifo_rd_drain #(
  parameter int data_width = 8,
  parameter int cnt_width  = 16
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic                  empty,
  input  logic [data_width-1:0] rdata,
  output logic                  rd_en,
  input  logic                  start,
  input  logic [cnt_width-1:0]  burst_len,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [cnt_width-1:0]  rd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [cnt_width-1:0]  issue_left_q, issue_left_d;
  logic                  inflight_q;
  logic [1:0]            occ_q;
  logic [data_width-1:0] buf0_q, buf1_q;
  logic                  pop;
  logic [2:0]            occ_net;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0_q;
  assign pop     = m_valid & m_ready;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  // Occupancy after this cycle's capture and pop; pops are only issued while
  // this leaves room for the word they will return.
  assign occ_net = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d      = state_q;
    issue_left_d = issue_left_q;
    rd_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            state_d      = READ;
            issue_left_d = burst_len;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (issue_left_q == '0) begin
          state_d = FLUSH;
        end else if (!empty && (occ_net < 3'd2)) begin
          rd_en        = 1'b1;
          issue_left_d = issue_left_q - cnt_width'(1);
          if (issue_left_q == cnt_width'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // look ahead so DONE follows the last handshake directly
        if (occ_net == 3'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      state_q      <= IDLE;
      issue_left_q <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      issue_left_q <= issue_left_d;
      inflight_q   <= rd_en;
      occ_q        <= occ_net[1:0];
      case ({inflight_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= rdata;
          else               buf1_q <= rdata;
        end
        2'b01: buf0_q <= buf1_q;
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= rdata;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_DRAIN_STAT_EN
  logic [cnt_width-1:0] rd_count_q;

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      rd_count_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      rd_count_q <= '0;
    end else if (pop) begin
      rd_count_q <= rd_count_q + cnt_width'(1);
    end
  end

  assign rd_count = rd_count_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a FIFO model feeds rdata, a scoreboard matches every
// handshake against the words the FIFO handed out, plus directed timing checks.
module tb_fifo_rd_drain;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          r_rst, empty, rd_en, start, m_valid, m_ready, busy, done;
  logic [DW-1:0] rdata, m_data;
  logic [CW-1:0] burst_len, rd_count;

  always #5 rclk = ~rclk;

  fifo_rd_drain #(.data_width(DW), .cnt_width(CW)) dut (
    .rclk(rclk), .r_rst(r_rst), .empty(empty), .rdata(rdata), .rd_en(rd_en),
    .start(start), .burst_len(burst_len), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done), .rd_count(rd_count)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] popped[$];
  logic [7:0] got[$];

  int cyc, pops, hs, done_cnt, done_cyc, first_rd, first_hs, last_hs;
  int burst_n, mode, stall_cnt;
  bit stall_first, rand_empty, pend, prev_stall;
  logic [7:0]    prev_data;
  logic          last_busy;
  logic [CW-1:0] last_rdc;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [31:0] exp_rc(input int n);
`ifdef FIFO_RD_DRAIN_STAT_EN
    return 32'(n % 65536);
`else
    return 32'(0 * n);
`endif
  endfunction

  task automatic observe();
    if (rd_en) begin
      pops++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (prev_stall) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(prev_data));
    end
    if (m_valid && m_ready) begin
      hs++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      got.push_back(m_data);
      if (popped.size() > 0) chk("word", 32'(m_data), 32'(popped.pop_front()));
      else                   chk("word_extra", 32'(popped.size()), 32'd1);
    end
    if (empty) chk("rd_en_when_empty", 32'(rd_en), 32'd0);
    chk("outstanding_le2", 32'((pops - hs) <= 2), 32'd1);
    chk("pop_limit", 32'(pops <= burst_n), 32'd1);
    if (stall_cnt > 0) chk("busy_in_stall", 32'(busy), 32'd1);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    last_busy  = busy;
    last_rdc   = rd_count;
    pend       = rd_en;
  endtask

  task automatic tick();
    @(negedge rclk);
    observe();
    @(posedge rclk);
    cyc++;
    #1;
    start = 1'b0;
    if (pend && fifo_q.size() > 0) begin
      rdata = fifo_q.pop_front();
      popped.push_back(rdata);
    end
    if (stall_first && pend && pops == 1) stall_cnt = 10;
    else if (stall_cnt > 0)               stall_cnt--;
    empty = (fifo_q.size() == 0) || (stall_cnt > 0) ||
            (rand_empty && ($urandom_range(0, 3) == 0));
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic clear_stats();
    pops = 0; hs = 0; done_cnt = 0; done_cyc = -1;
    first_rd = -1; first_hs = -1; last_hs = -1;
    got.delete();
    prev_stall = 1'b0; stall_cnt = 0; pend = 1'b0;
  endtask

  task automatic run_burst(input int len, input int md, input bit stall1,
                           input bit rnd_e, input bit inject, input bit ideal);
    int guard;
    clear_stats();
    burst_n = len; mode = md; stall_first = stall1; rand_empty = rnd_e;
    m_ready   = (md == 3) ? 1'b0 : 1'b1;
    empty     = (fifo_q.size() == 0);
    start     = 1'b1;
    burst_len = CW'(len);
    cyc       = 0;
    guard     = 0;
    while (done_cnt == 0 && guard < 500) begin
      tick();
      guard++;
      if (inject && cyc == 4) begin
        start     = 1'b1;
        burst_len = CW'(len + 5);
      end
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
    tick();
    chk("busy_after_done", 32'(last_busy), 32'd0);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("pop_count", 32'(pops), 32'(len));
    chk("handshakes", 32'(hs), 32'(len));
    chk("rd_count", 32'(last_rdc), exp_rc(len));
    if (ideal) begin
      chk("done_cycle", 32'(done_cyc), 32'(len + 3 - ((len == 0) ? 2 : 0)));
      if (len > 0) begin
        chk("first_rd_cycle", 32'(first_rd), 32'd1);
        chk("first_hs_cycle", 32'(first_hs), 32'd3);
        chk("last_hs_cycle", 32'(last_hs), 32'(len + 2));
      end
    end
  endtask

  task automatic chk_words(input string tag, input int n, input logic [7:0] base);
    chk({tag, "_n"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk(tag, 32'(got[i]), 32'(8'(base + 8'(i))));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd_count"}, 32'(rd_count), 32'd0);
  endtask

  initial begin
    int n;
    r_rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b1;
    empty = 1'b1; rdata = '0; mode = 0; burst_n = 0;
    stall_first = 1'b0; rand_empty = 1'b0; cyc = 0;
    clear_stats();
    #2;
    chk_all_zero("reset");
    @(posedge rclk); #1;
    r_rst = 1'b0;

    // basic burst of 4
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(i + 1));
    run_burst(4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_words("basic_data", 4, 8'h01);

    // backpressure, ready toggling
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h10 + i));
    run_burst(6, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_words("bp_data", 6, 8'h10);

    // empty stall after first pop
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'(8'h20 + i));
    run_burst(3, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_words("stall_data", 3, 8'h20);

    // zero length
    run_burst(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("zero_no_rd_en", 32'(first_rd), 32'hFFFF_FFFF);

    // start during busy burst is ignored
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h30 + i));
    run_burst(5, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_words("ign_data", 5, 8'h30);
    chk("ign_fifo_left", 32'(fifo_q.size()), 32'd0);

    // reset while the buffer is full
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'(8'hA0 + i));
    clear_stats();
    burst_n = 8; mode = 3; m_ready = 1'b0; empty = 1'b0;
    start = 1'b1; burst_len = CW'(8); cyc = 0;
    repeat (6) tick();
    chk("rst_pops_before", 32'(pops), 32'd2);
    r_rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    popped.delete();
    prev_stall = 1'b0; pend = 1'b0;
    @(posedge rclk); #1;
    r_rst = 1'b0;
    run_burst(2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_words("after_rst_data", 2, 8'hA2);

    // randomized bursts: random ready and random empty gaps
    for (int b = 0; b < 6; b++) begin
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
      run_burst(n, int'($urandom_range(0, 2)), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
